// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, colour/address widths, clear_lines state encoding and score table.
package tetris_pkg;
    localparam int BOARD_W     = 10;
    localparam int BOARD_H     = 24;
    localparam int HIDDEN_ROWS = 4;
    localparam int COLOUR_W    = 6;
    localparam int ADDR_W      = 8;
    localparam int X_W         = 4;
    localparam int Y_W         = 5;
    localparam int ROW_W       = Y_W + 1;

    localparam logic [COLOUR_W-1:0] EMPTY_COLOUR = 6'h00;
    localparam logic [ROW_W-1:0]    TOP_ROW      = ROW_W'(BOARD_H - 1);
    localparam logic [X_W-1:0]      LAST_X       = X_W'(BOARD_W - 1);
    localparam logic [X_W-1:0]      CHECK_LAST   = X_W'(BOARD_W);
    localparam logic [2:0]          MAX_LINES    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COPY_RD,
        S_COPY_WR,
        S_FILL,
        S_DONE
    } state_t;

    function automatic logic [15:0] score_pts(input logic [2:0] n);
        return (n == 3'd1) ? 16'd1 :
               (n == 3'd2) ? 16'd3 :
               (n == 3'd3) ? 16'd5 :
               (n >= 3'd4) ? 16'd8 : 16'd0;
    endfunction
endpackage

// File: rtl/coord_to_addr.sv
// coord_to_addr: board cell (x,y) to linear RAM address y*BOARD_W + x.
module coord_to_addr
    import tetris_pkg::*;
(
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    x,
    output logic [ADDR_W-1:0] addr
);
    assign addr = ADDR_W'(y) * ADDR_W'(BOARD_W) + ADDR_W'(x);
endmodule

// File: rtl/clear_lines.sv
// clear_lines: bottom-up full-row removal and board compaction over a single-port board RAM.
// Optional CLEAR_LINES_SCORE_EN adds a saturating score output.
module clear_lines
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COLOUR_W-1:0] ram_Q,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [COLOUR_W-1:0] ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                done,
    output logic [2:0]          lines_cleared
`ifdef CLEAR_LINES_SCORE_EN
    ,
    output logic [15:0]         score
`endif
);
    state_t             state;
    logic [ROW_W-1:0]   src, dst, src_n, dst_n;
    logic [X_W-1:0]     x, col;
    logic [Y_W-1:0]     row;
    logic [2:0]         count;
    logic               full, row_full, fill_on, active;
    logic [ADDR_W-1:0]  cell_addr;

    // pointers carry a sign bit so stepping below row 0 shows up as a borrow
    assign src_n    = src - ROW_W'(1);
    assign dst_n    = dst - ROW_W'(1);
    assign row_full = full & (ram_Q != EMPTY_COLOUR);
    assign fill_on  = (state == S_FILL) && !dst[ROW_W-1];
    assign active   = (state == S_CHECK) || (state == S_COPY_RD) || (state == S_COPY_WR) || fill_on;
    assign row      = (state == S_COPY_WR || state == S_FILL) ? dst[Y_W-1:0] : src[Y_W-1:0];
    assign col      = (x > LAST_X) ? LAST_X : x;
    assign ram_addr = active ? cell_addr : '0;
    assign ram_wren = (state == S_COPY_WR) || fill_on;
    assign ram_data = (state == S_COPY_WR) ? ram_Q : EMPTY_COLOUR;

    coord_to_addr u_addr (.y(row), .x(col), .addr(cell_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            src           <= TOP_ROW;
            dst           <= TOP_ROW;
            x             <= '0;
            count         <= '0;
            full          <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_CHECK;
                    busy  <= 1'b1;
                    src   <= TOP_ROW;
                    dst   <= TOP_ROW;
                    x     <= '0;
                    count <= '0;
                end
                S_CHECK: begin
                    // read data lags the address by one cycle, so cell k is judged at step k+1
                    full <= (x == '0) ? 1'b1 : row_full;
                    x    <= (x == CHECK_LAST) ? '0 : x + X_W'(1);
                    if (x == CHECK_LAST) begin
                        if (row_full) begin
                            count <= (count == MAX_LINES) ? count : count + 3'd1;
                            src   <= src_n;
                            state <= src_n[ROW_W-1] ? S_FILL : S_CHECK;
                        end else if (src == dst) begin
                            src   <= src_n;
                            dst   <= dst_n;
                            state <= src_n[ROW_W-1] ? S_FILL : S_CHECK;
                        end else begin
                            state <= S_COPY_RD;
                        end
                    end
                end
                S_COPY_RD: state <= S_COPY_WR;
                S_COPY_WR: begin
                    x <= (x == LAST_X) ? '0 : x + X_W'(1);
                    if (x == LAST_X) begin
                        src   <= src_n;
                        dst   <= dst_n;
                        state <= src_n[ROW_W-1] ? S_FILL : S_CHECK;
                    end else begin
                        state <= S_COPY_RD;
                    end
                end
                S_FILL: if (dst[ROW_W-1]) begin
                    state         <= S_DONE;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    lines_cleared <= count;
                end else begin
                    x <= (x == LAST_X) ? '0 : x + X_W'(1);
                    if (x == LAST_X) dst <= dst_n;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CLEAR_LINES_SCORE_EN
    logic [16:0] score_sum;
    assign score_sum = {1'b0, score} + {1'b0, score_pts(count)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) score <= '0;
        else if (state == S_FILL && dst[ROW_W-1]) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_clear_lines.sv
// tb_clear_lines: directed and random boards against a row-compaction reference model.
module tb_clear_lines;
    logic       clk = 1'b0;
    logic       reset, start, load_req;
    logic [5:0] ram_Q = 6'h00;
    logic [7:0] ram_addr;
    logic [5:0] ram_data;
    logic       ram_wren, busy, done;
    logic [2:0] lines_cleared;
    int         tests = 0, fails = 0, wr_count = 0;
    logic [5:0] mem     [240];
    logic [5:0] img     [240];
    logic [5:0] exp_mem [240];
`ifdef CLEAR_LINES_SCORE_EN
    logic [15:0] score;
    int          score_exp = 0;
    int          pts [5] = '{0, 1, 3, 5, 8};
`endif

    clear_lines dut (
        .clk(clk), .reset(reset), .start(start), .ram_Q(ram_Q), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_wren(ram_wren), .busy(busy), .done(done),
        .lines_cleared(lines_cleared)
`ifdef CLEAR_LINES_SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk = ~clk;

    // single-port board RAM with one-cycle read latency
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 240; i++) mem[i] <= img[i];
        end else if (ram_wren && ram_addr < 8'd240) begin
            mem[ram_addr] <= ram_data;
        end
        if (ram_wren) wr_count <= wr_count + 1;
        ram_Q <= (ram_addr < 8'd240) ? mem[ram_addr] : 6'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 240; i++) img[i] = 6'h00;
    endtask

    task automatic set_row(input int y, input int lo, input int hi, input logic [5:0] c);
        for (int x = lo; x <= hi; x++) img[y*10+x] = c;
    endtask

    // surviving rows keep their order and sink to the bottom; empty rows fill the top
    task automatic model(output int lines);
        int r;
        bit f;
        r = 23;
        lines = 0;
        for (int y = 23; y >= 0; y--) begin
            f = 1;
            for (int x = 0; x < 10; x++) if (img[y*10+x] == 6'h00) f = 0;
            if (f) lines++;
            else begin
                for (int x = 0; x < 10; x++) exp_mem[r*10+x] = img[y*10+x];
                r--;
            end
        end
        for (int y = r; y >= 0; y--) for (int x = 0; x < 10; x++) exp_mem[y*10+x] = 6'h00;
    endtask

    task automatic run(input string tag, input int restart_at, input int exp_writes);
        int lines, cyc, w0, bad, dones;
        model(lines);
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
        w0 = wr_count;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, done, 1);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " lines_cleared"}, lines_cleared, lines);
`ifdef CLEAR_LINES_SCORE_EN
        score_exp = score_exp + pts[lines];
        if (score_exp > 65535) score_exp = 65535;
        check({tag, " score"}, score, score_exp);
`endif
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check({tag, " single_done"}, dones, 0);
        check({tag, " lines_held"}, lines_cleared, lines);
        if (exp_writes >= 0) check({tag, " writes"}, wr_count - w0, exp_writes);
        bad = 0;
        for (int i = 0; i < 240; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({tag, " bad_cells"}, bad, 0);
    endtask

    initial begin
        int cyc, nf;
        reset = 1'b1;
        start = 1'b0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset wren", ram_wren, 0);
        check("reset addr", ram_addr, 0);
        check("reset data", ram_data, 0);
        check("reset lines", lines_cleared, 0);
        reset = 1'b0;

        clear_img();
        run("empty", -1, 0);

        clear_img();
        set_row(23, 0, 9, 6'h15);
        set_row(22, 0, 4, 6'h0C);
        run("row23", -1, 240);
        check("row23 cell_23_4", mem[23*10+4], 6'h0C);
        check("row23 cell_23_5", mem[23*10+5], 6'h00);

        clear_img();
        set_row(23, 0, 9, 6'h11);
        set_row(21, 0, 9, 6'h22);
        set_row(22, 3, 3, 6'h30);
        run("gap", -1, 240);
        check("gap marker", mem[23*10+3], 6'h30);

        clear_img();
        for (int y = 20; y < 24; y++) set_row(y, 0, 9, 6'(y));
        run("four", -1, 240);

        clear_img();
        set_row(23, 0, 9, 6'h15);
        set_row(22, 0, 4, 6'h0C);
        run("restart", 50, 240);

        for (int t = 0; t < 6; t++) begin
            nf = 0;
            for (int y = 0; y < 24; y++) begin
                if (nf < 4 && $urandom_range(0, 3) == 0) begin
                    for (int x = 0; x < 10; x++) img[y*10+x] = 6'($urandom_range(1, 63));
                    nf++;
                end else begin
                    for (int x = 0; x < 10; x++)
                        img[y*10+x] = $urandom_range(0, 1) ? 6'($urandom_range(1, 63)) : 6'h00;
                    img[y*10+$urandom_range(0, 9)] = 6'h00;
                end
            end
            run($sformatf("rand%0d", t), -1, -1);
        end

        clear_img();
        set_row(23, 0, 9, 6'h15);
        set_row(22, 0, 9, 6'h0C);
        set_row(22, 9, 9, 6'h00);
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!ram_wren && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset reached_copy", ram_wren, 1);
        reset = 1'b1;
        #1;
        check("midreset busy", busy, 0);
        check("midreset wren", ram_wren, 0);
        check("midreset addr", ram_addr, 0);
        check("midreset data", ram_data, 0);
        check("midreset lines", lines_cleared, 0);
`ifdef CLEAR_LINES_SCORE_EN
        check("midreset score", score, 0);
        score_exp = 0;
`endif
        @(negedge clk) reset = 1'b0;
        run("after_reset", -1, 240);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
